// File: rtl/traffic_phase_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg: phase codes and approach indices for the junction scheduler.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package traffic_pkg;

    localparam int N_APP = 5;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_ALL_RED = 2'b00;
    localparam phase_t PH_GREEN   = 2'b01;
    localparam phase_t PH_YELLOW  = 2'b10;

    localparam logic [2:0] MID = 3'd0;
    localparam logic [2:0] L   = 3'd1;
    localparam logic [2:0] R   = 3'd2;
    localparam logic [2:0] T   = 3'd3;
    localparam logic [2:0] D   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/traffic_phase_scheduler_if.sv
// ---------------------------------------------------------------------------
// traffic_phase_scheduler_if: demand inputs and signal-head outputs.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface traffic_phase_scheduler_if
    import traffic_pkg::*;
#(
    parameter int DW = 5,
    parameter int PW = 4,
    parameter int TW = 8
);
    logic                  tick;
    logic [N_APP*DW-1:0]   density_i;
    logic [N_APP*PW-1:0]   prio_i;
    logic [N_APP*PW-1:0]   emerg_i;
    logic [N_APP-1:0]      grant_o;
    logic [N_APP-1:0]      amber_o;
    logic                  all_red_o;
    logic [1:0]            phase_o;
    logic [2:0]            cur_idx_o;
    logic [TW-1:0]         timer_o;
    logic [N_APP-1:0]      starve_o;

    modport master (
        output tick, density_i, prio_i, emerg_i,
        input  grant_o, amber_o, all_red_o, phase_o, cur_idx_o, timer_o, starve_o
    );

    modport slave (
        input  tick, density_i, prio_i, emerg_i,
        output grant_o, amber_o, all_red_o, phase_o, cur_idx_o, timer_o, starve_o
    );
endinterface

`default_nettype wire

// File: rtl/traffic_phase_scheduler_pick.sv
// ---------------------------------------------------------------------------
// traffic_pick: combinational next-green winner selector.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module traffic_pick
    import traffic_pkg::*;
#(
    parameter int DW = 5,
    parameter int PW = 4
)(
    input  logic [N_APP*DW-1:0] density_i,
    input  logic [N_APP*PW-1:0] prio_i,
    input  logic [N_APP*PW-1:0] emerg_i,
    input  logic [N_APP-1:0]    starve_i,
    input  logic [2:0]          rr_ptr_i,
    output logic                valid_o,
    output logic [2:0]          idx_o
);
    localparam int KW = PW + DW;

    logic              any_emerg;
    logic              any_starved;
    logic [N_APP-1:0]  elig;
    logic [KW-1:0]     key [N_APP];
    logic [KW-1:0]     best_key;
    logic [3:0]        rr_sum;
    logic [2:0]        cand;

    // One eligibility/key pair per approach; the active class decides both.
    always_comb begin
        any_emerg   = 1'b0;
        any_starved = 1'b0;
        for (int k = 0; k < N_APP; k++) begin
            if (emerg_i[PW*k +: PW] != '0) any_emerg = 1'b1;
            if (starve_i[k] && density_i[DW*k +: DW] != '0) any_starved = 1'b1;
        end
        for (int k = 0; k < N_APP; k++) begin
            if (any_emerg) begin
                elig[k] = (emerg_i[PW*k +: PW] != '0);
                key[k]  = {emerg_i[PW*k +: PW], {DW{1'b0}}};
            end else if (any_starved) begin
                elig[k] = starve_i[k] && (density_i[DW*k +: DW] != '0);
                key[k]  = '0;
            end else begin
                elig[k] = (density_i[DW*k +: DW] != '0);
                key[k]  = {prio_i[PW*k +: PW], density_i[DW*k +: DW]};
            end
        end
    end

    // Scan in round-robin order with strict compare, so ties go to the first visited.
    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        best_key = '0;
        rr_sum   = '0;
        cand     = '0;
        for (int j = 1; j <= N_APP; j++) begin
            rr_sum = {1'b0, rr_ptr_i} + 4'(j);
            if (rr_sum >= 4'(N_APP)) rr_sum = rr_sum - 4'(N_APP);
            cand = rr_sum[2:0];
            if (elig[cand] && (!valid_o || key[cand] > best_key)) begin
                valid_o  = 1'b1;
                idx_o    = cand;
                best_key = key[cand];
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
// ---------------------------------------------------------------------------
// traffic_phase_scheduler: single-green GREEN/YELLOW/ALL_RED junction sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int DW         = 5,
    parameter int PW         = 4,
    parameter int TW         = 8,
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 20,
    parameter int GREEN_STEP = 1,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 1,
    parameter int MAX_WAIT   = 60
)(
    input  logic                        clk,
    input  logic                        rst,
    traffic_phase_scheduler_if.slave    bus
);
    localparam int            WW        = $clog2(MAX_WAIT + 1);
    localparam logic [TW-1:0] ONE_T     = TW'(1);
    localparam logic [TW-1:0] MIN_T     = TW'(MIN_GREEN);
    localparam logic [TW-1:0] YELLOW_TV = TW'(YELLOW_T);
    localparam logic [TW-1:0] ALLRED_TV = TW'(ALLRED_T);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);

    phase_t                      phase_q, phase_d;
    logic [TW-1:0]               timer_q, timer_d;
    logic [2:0]                  cur_idx_q, cur_idx_d;
    logic [2:0]                  rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]               green_el_q, green_el_d;
    logic [N_APP-1:0][WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [N_APP-1:0]            starve_q, starve_d;
    logic [N_APP-1:0]            grant_q, grant_d;
    logic [N_APP-1:0]            amber_q, amber_d;
    logic                        all_red_q, all_red_d;

    logic                        pick_valid;
    logic [2:0]                  pick_idx;
    logic                        own_emerg;
    logic                        other_emerg;
    logic                        preempt;
    logic                        gap_out;
    logic                        enter_green;

    // Computed wide so a large density cannot wrap before the cap is applied.
    function automatic logic [TW-1:0] green_time(input logic [DW-1:0] dens);
        int t;
        t = MIN_GREEN + int'(dens) * GREEN_STEP;
        if (t > MAX_GREEN) t = MAX_GREEN;
        return TW'(t);
    endfunction

    traffic_pick #(
        .DW (DW),
        .PW (PW)
    ) u_pick (
        .density_i (bus.density_i),
        .prio_i    (bus.prio_i),
        .emerg_i   (bus.emerg_i),
        .starve_i  (starve_q),
        .rr_ptr_i  (rr_ptr_q),
        .valid_o   (pick_valid),
        .idx_o     (pick_idx)
    );

    always_comb begin
        own_emerg   = (bus.emerg_i[PW*cur_idx_q +: PW] != '0);
        other_emerg = 1'b0;
        for (int k = 0; k < N_APP; k++) begin
            if (3'(k) != cur_idx_q && bus.emerg_i[PW*k +: PW] != '0) other_emerg = 1'b1;
        end
        preempt = other_emerg && !own_emerg;
        gap_out = (bus.density_i[DW*cur_idx_q +: DW] == '0) && (green_el_q >= MIN_T);
    end

    always_comb begin
        phase_d     = phase_q;
        timer_d     = timer_q;
        cur_idx_d   = cur_idx_q;
        rr_ptr_d    = rr_ptr_q;
        green_el_d  = green_el_q;
        enter_green = 1'b0;

        case (phase_q)
            PH_ALL_RED: begin
                if (bus.tick) begin
                    if (timer_q > ONE_T) begin
                        timer_d = timer_q - ONE_T;
                    end else if (pick_valid) begin
                        phase_d     = PH_GREEN;
                        cur_idx_d   = pick_idx;
                        rr_ptr_d    = pick_idx;
                        timer_d     = green_time(bus.density_i[DW*pick_idx +: DW]);
                        green_el_d  = '0;
                        enter_green = 1'b1;
                    end else begin
                        timer_d = ALLRED_TV;
                    end
                end
            end
            PH_GREEN: begin
                if (bus.tick && green_el_q != '1) green_el_d = green_el_q + ONE_T;
                // Preempt and gap-out bypass tick; own emergency freezes the countdown.
                if (preempt || gap_out || (bus.tick && !own_emerg && timer_q <= ONE_T)) begin
                    phase_d = PH_YELLOW;
                    timer_d = YELLOW_TV;
                end else if (bus.tick && !own_emerg) begin
                    timer_d = timer_q - ONE_T;
                end
            end
            PH_YELLOW: begin
                if (bus.tick) begin
                    if (timer_q > ONE_T) begin
                        timer_d = timer_q - ONE_T;
                    end else begin
                        phase_d = PH_ALL_RED;
                        timer_d = ALLRED_TV;
                    end
                end
            end
            default: begin
                phase_d = PH_ALL_RED;
                timer_d = ALLRED_TV;
            end
        endcase

        for (int k = 0; k < N_APP; k++) begin
            wait_cnt_d[k] = wait_cnt_q[k];
            if (bus.density_i[DW*k +: DW] == '0 || (enter_green && pick_idx == 3'(k))) begin
                wait_cnt_d[k] = '0;
            end else if (bus.tick && !(phase_q == PH_GREEN && cur_idx_q == 3'(k))
                         && wait_cnt_q[k] < WAIT_MAX) begin
                wait_cnt_d[k] = wait_cnt_q[k] + WW'(1);
            end
            starve_d[k] = (wait_cnt_d[k] >= WAIT_MAX);
        end

        grant_d   = (phase_d == PH_GREEN)  ? (N_APP'(1) << cur_idx_d) : '0;
        amber_d   = (phase_d == PH_YELLOW) ? (N_APP'(1) << cur_idx_d) : '0;
        all_red_d = (phase_d == PH_ALL_RED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= PH_ALL_RED;
            timer_q    <= ALLRED_TV;
            cur_idx_q  <= '0;
            rr_ptr_q   <= 3'(N_APP - 1);
            green_el_q <= '0;
            wait_cnt_q <= '0;
            starve_q   <= '0;
            grant_q    <= '0;
            amber_q    <= '0;
            all_red_q  <= 1'b1;
        end else begin
            phase_q    <= phase_d;
            timer_q    <= timer_d;
            cur_idx_q  <= cur_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            green_el_q <= green_el_d;
            wait_cnt_q <= wait_cnt_d;
            starve_q   <= starve_d;
            grant_q    <= grant_d;
            amber_q    <= amber_d;
            all_red_q  <= all_red_d;
        end
    end

    assign bus.grant_o   = grant_q;
    assign bus.amber_o   = amber_q;
    assign bus.all_red_o = all_red_q;
    assign bus.phase_o   = phase_q;
    assign bus.cur_idx_o = cur_idx_q;
    assign bus.timer_o   = timer_q;
    assign bus.starve_o  = starve_q;
endmodule

`default_nettype wire
